dist_rom_stream_m: RTL

- Address sequencer and output buffer in front of a distributed ROM (combinational or output-registered variant).
- On a start command, reads LEN consecutive words from a base address, wrapping modulo ROM size.
- Presents the words on a valid/ready stream with a last flag.
- Absorbs ROM read latency and downstream backpressure with a 2-entry buffer, so no word is lost or duplicated.

---
 rtl/dist_rom_stream_if.sv | 23 ++
 rtl/dist_rom_stream_m.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dist_rom_stream_if.sv
// Valid/ready word stream with an end-of-command marker.
interface dist_rom_stream_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/dist_rom_stream_m.sv
// Address sequencer + 2-entry output buffer for a distributed ROM.
// Optional repeat-pass support via `DIST_ROM_STREAM_LOOP_EN.
module dist_rom_stream_m #(
    parameter int ADDR_WIDTH  = 6,
    parameter int WORD_WIDTH  = 16,
    parameter int LEN_WIDTH   = ADDR_WIDTH + 1,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
`ifdef DIST_ROM_STREAM_LOOP_EN
    input  logic                  loop,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [WORD_WIDTH-1:0] rom_data,
    dist_rom_stream_if.master     m
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  remaining;

    logic                  tail_valid;
    logic                  tail_last;
    logic [WORD_WIDTH-1:0] tail_data;

    logic                  in_flight;
    logic                  push;
    logic                  push_last;
    logic [WORD_WIDTH-1:0] push_data;

    logic [1:0] occ;
    logic [1:0] pend;
    logic       pop;
    logic       issue;
    logic       issue_last;
    logic       loop_now;
    logic       reload;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    assign occ  = {1'b0, m.m_valid} + {1'b0, tail_valid};
    assign pop  = m.m_valid & m.m_ready;
    // Words that will occupy the buffer next cycle before any new issue
    assign pend = occ + {1'b0, in_flight} - {1'b0, pop};

    assign issue = (state == S_RUN) &&
                   (remaining != '0) &&
                   (pend < 2'd2);
    assign issue_last = issue && (remaining == LEN_WIDTH'(1));

`ifdef DIST_ROM_STREAM_LOOP_EN
    assign loop_now = loop;
`else
    assign loop_now = 1'b0;
`endif
    assign reload = issue_last & loop_now;

    if (ROM_LATENCY == 0) begin : g_lat0
        assign in_flight = 1'b0;
        assign push      = issue;
        assign push_last = issue_last;
        assign push_data = rom_data;
    end else if (ROM_LATENCY == 1) begin : g_lat1
        logic fl_q;
        logic fl_last_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                fl_q      <= 1'b0;
                fl_last_q <= 1'b0;
            end else begin
                fl_q      <= issue;
                fl_last_q <= issue_last;
            end
        end
        assign in_flight = fl_q;
        assign push      = fl_q;
        assign push_last = fl_last_q;
        assign push_data = rom_data;
    end else begin : g_bad_latency
        $error("dist_rom_stream_m: ROM_LATENCY must be 0 or 1");
        assign in_flight = 1'b0;
        assign push      = 1'b0;
        assign push_last = 1'b0;
        assign push_data = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            remaining <= '0;
            rom_addr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        len_q     <= len;
                        remaining <= len;
                        rom_addr  <= base_addr;
                        // Empty command drains trivially, giving done in cycle 2
                        state     <= (len == '0) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        if (reload) begin
                            rom_addr  <= base_q;
                            remaining <= len_q;
                        end else begin
                            rom_addr  <= rom_addr + ADDR_WIDTH'(1);
                            remaining <= remaining - LEN_WIDTH'(1);
                        end
                        if (issue_last && !reload) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pend == 2'd0) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m.m_valid  <= 1'b0;
            m.m_data   <= '0;
            m.m_last   <= 1'b0;
            tail_valid <= 1'b0;
            tail_data  <= '0;
            tail_last  <= 1'b0;
        end else if (!m.m_valid || pop) begin
            if (tail_valid) begin
                m.m_valid  <= 1'b1;
                m.m_data   <= tail_data;
                m.m_last   <= tail_last;
                tail_valid <= push;
                if (push) begin
                    tail_data <= push_data;
                    tail_last <= push_last;
                end
            end else begin
                m.m_valid <= push;
                m.m_last  <= push & push_last;
                if (push) m.m_data <= push_data;
            end
        end else if (push) begin
            tail_valid <= 1'b1;
            tail_data  <= push_data;
            tail_last  <= push_last;
        end
    end

endmodule
